// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial wide adder.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_4bit.sv
// Existing 4-bit adder stage: {C_o, S_o} = A_i + B_i + C_i.
module full_adder_4bit (
  input  logic [3:0] A_i,
  input  logic [3:0] B_i,
  input  logic       C_i,
  output logic [3:0] S_o,
  output logic       C_o
);

  // Widen to 5 bits so the carry-out falls out of the addition.
  assign {C_o, S_o} = {1'b0, A_i} + {1'b0, B_i} + {4'b0000, C_i};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder: reuses one 4-bit stage, one nibble per clock,
// LSB first, with the inter-nibble carry held in a register.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [NIBBLE_W*NIBBLES-1:0] A_i,
  input  logic [NIBBLE_W*NIBBLES-1:0] B_i,
  input  logic                        C_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [NIBBLE_W*NIBBLES-1:0] S_o,
  output logic                        C_o
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = $clog2(NIBBLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  state_t           state;
  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       stage_s;
  logic             stage_c;
  logic [W-1:0]     s_next;

  full_adder_4bit u_stage (
    .A_i (a_sh[3:0]),
    .B_i (b_sh[3:0]),
    .C_i (carry),
    .S_o (stage_s),
    .C_o (stage_c)
  );

  // New stage sum enters at the top nibble; after NIBBLES shifts the first
  // (LSB) nibble has reached bits [3:0]. Shift form also covers NIBBLES = 1.
  always_comb begin
    s_next = (S_o >> NIBBLE_W) | (W'(stage_s) << (W - NIBBLE_W));
  end

  // Control FSM plus operand/accumulator datapath, all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      S_o         <= '0;
      C_o         <= 1'b0;
      a_sh        <= '0;
      b_sh        <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            a_sh       <= A_i;
            b_sh       <= B_i;
            carry      <= C_i;
            cnt        <= '0;
            S_o        <= '0;
            in_ready_o <= 1'b0;
            state      <= ADD;
          end
        end
        ADD: begin
          S_o   <= s_next;
          carry <= stage_c;
          a_sh  <= a_sh >> NIBBLE_W;
          b_sh  <= b_sh >> NIBBLE_W;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            C_o         <= stage_c;
            out_valid_o <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: a 16-bit (NIBBLES=4) and a 4-bit (NIBBLES=1) adder,
// directed cases plus random operands against a plain arithmetic model.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // NIBBLES = 4 instance
  logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b0, c4 = 1'b0, co4;
  logic [15:0] a4 = '0, b4 = '0, s4;
  // NIBBLES = 1 instance
  logic        iv1 = 1'b0, ir1, ov1, or1 = 1'b0, c1 = 1'b0, co1;
  logic [3:0]  a1 = '0, b1 = '0, s1;

  int tests = 0;
  int fails = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv4), .in_ready_o(ir4),
    .A_i(a4), .B_i(b4), .C_i(c4), .out_valid_o(ov4), .out_ready_i(or4),
    .S_o(s4), .C_o(co4)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv1), .in_ready_o(ir1),
    .A_i(a1), .B_i(b1), .C_i(c1), .out_valid_o(ov1), .out_ready_i(or1),
    .S_o(s1), .C_o(co1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on dut4, wait for the result, check value and
  // latency, then consume it after 'hold' stall cycles.
  task automatic run_op4(input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [15:0] a_after,
                         input int hold, input string name);
    logic [16:0] exp;
    logic [15:0] held;
    int cyc;
    exp = {1'b0, a} + {1'b0, b} + {16'd0, c};
    tests++;
    if (ir4 !== 1'b1) begin
      fails++; $display("FAIL %s ready_before: got %b want 1", name, ir4);
    end
    iv4 = 1'b1; a4 = a; b4 = b; c4 = c;
    step();
    iv4 = 1'b0; a4 = a_after; b4 = ~b; c4 = ~c;
    cyc = 0;
    while (ov4 !== 1'b1 && cyc < 20) begin
      tests++;
      if (ir4 !== 1'b0) begin
        fails++; $display("FAIL %s ready_busy: got %b want 0", name, ir4);
      end
      step();
      cyc++;
    end
    tests++;
    if (cyc !== 4) begin
      fails++; $display("FAIL %s latency: got %0d want 4", name, cyc);
    end
    tests++;
    if ({co4, s4} !== exp) begin
      fails++; $display("FAIL %s sum: got %h want %h", name, {co4, s4}, exp);
    end
    held = s4;
    for (int i = 0; i < hold; i++) begin
      iv4 = 1'b1; a4 = 16'h0001;
      step();
      tests++;
      if (ov4 !== 1'b1 || ir4 !== 1'b0 || {co4, s4} !== exp) begin
        fails++;
        $display("FAIL %s stall%0d: got v=%b r=%b %h want v=1 r=0 %h",
                 name, i, ov4, ir4, {co4, s4}, exp);
      end
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    step();
    or4 = 1'b0;
    tests++;
    if (ov4 !== 1'b0 || ir4 !== 1'b1 || s4 !== held) begin
      fails++;
      $display("FAIL %s release: got v=%b r=%b s=%h want v=0 r=1 s=%h",
               name, ov4, ir4, s4, held);
    end
  endtask

  task automatic run_op1(input logic [3:0] a, input logic [3:0] b,
                         input logic c, input string name);
    logic [4:0] exp;
    int cyc;
    exp = {1'b0, a} + {1'b0, b} + {4'd0, c};
    iv1 = 1'b1; a1 = a; b1 = b; c1 = c;
    step();
    iv1 = 1'b0; a1 = ~a; b1 = ~b;
    cyc = 0;
    while (ov1 !== 1'b1 && cyc < 10) begin
      step();
      cyc++;
    end
    tests++;
    if (cyc !== 1) begin
      fails++; $display("FAIL %s latency: got %0d want 1", name, cyc);
    end
    tests++;
    if ({co1, s1} !== exp) begin
      fails++; $display("FAIL %s sum: got %h want %h", name, {co1, s1}, exp);
    end
    or1 = 1'b1;
    step();
    or1 = 1'b0;
    tests++;
    if (ov1 !== 1'b0 || ir1 !== 1'b1) begin
      fails++; $display("FAIL %s release: got v=%b r=%b want 0 1", name, ov1, ir1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    tests++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0 || s4 !== 16'h0 || co4 !== 1'b0) begin
      fails++;
      $display("FAIL reset4: got r=%b v=%b s=%h c=%b want 1 0 0000 0", ir4, ov4, s4, co4);
    end
    tests++;
    if (ir1 !== 1'b1 || ov1 !== 1'b0 || s1 !== 4'h0 || co1 !== 1'b0) begin
      fails++;
      $display("FAIL reset1: got r=%b v=%b s=%h c=%b want 1 0 0 0", ir1, ov1, s1, co1);
    end
  endtask

  task automatic test_directed();
    run_op4(16'h000A, 16'h0005, 1'b0, 16'h1111, 0, "simple");
    run_op4(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 0, "ripple");
    run_op4(16'h1234, 16'h4321, 1'b1, 16'hAAAA, 0, "in_change");
  endtask

  task automatic test_backpressure();
    run_op4(16'h0F0F, 16'h00F1, 1'b0, 16'h5555, 3, "backpressure");
    run_op4(16'h0001, 16'h0002, 1'b0, 16'h0000, 0, "after_bp");
  endtask

  task automatic test_reset_midop();
    iv4 = 1'b1; a4 = 16'h00FF; b4 = 16'h0001; c4 = 1'b0;
    step();
    iv4 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0 || s4 !== 16'h0 || co4 !== 1'b0) begin
      fails++;
      $display("FAIL reset_midop: got r=%b v=%b s=%h c=%b want 1 0 0000 0", ir4, ov4, s4, co4);
    end
    run_op4(16'h0003, 16'h0007, 1'b0, 16'hFFFF, 0, "post_reset");
    // Reset in DONE discards the held result.
    iv4 = 1'b1; a4 = 16'h8000; b4 = 16'h8000; c4 = 1'b1;
    step();
    iv4 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (ov4 !== 1'b0 || s4 !== 16'h0 || co4 !== 1'b0 || ir4 !== 1'b1) begin
      fails++;
      $display("FAIL reset_done: got r=%b v=%b s=%h c=%b want 1 0 0000 0", ir4, ov4, s4, co4);
    end
    // Reset beats a simultaneous request.
    rst = 1'b1; iv4 = 1'b1; a4 = 16'h1111; b4 = 16'h2222;
    step();
    rst = 1'b0; iv4 = 1'b0;
    step();
    step();
    tests++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0) begin
      fails++; $display("FAIL reset_vs_valid: got r=%b v=%b want 1 0", ir4, ov4);
    end
  endtask

  task automatic test_nibbles1();
    run_op1(4'h3, 4'h7, 1'b0, "n1_a");
    run_op1(4'hA, 4'h5, 1'b1, "n1_b");
    for (int i = 0; i < 20; i++)
      run_op1(4'($urandom), 4'($urandom), 1'($urandom), "n1_rand");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_op4(16'($urandom), 16'($urandom), 1'($urandom), 16'($urandom),
              int'($urandom_range(0, 2)), "rand");
    run_op4(16'hFFFF, 16'hFFFF, 1'b1, 16'h0, 0, "max");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_nibbles1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
